irq_controller: RTL and testbench



---
 rtl/irq_controller_pkg.sv | 30 +++
 rtl/irq_controller_if.sv | 23 ++
 rtl/irq_controller_prio_enc.sv | 23 ++
 rtl/irq_controller.sv | 158 +++++++++++++++
 tb/tb_irq_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// controller state encoding and the CLAIM read-word layout.
package irq_controller_pkg;

  localparam int BUS_W = 32;

  // Register offsets on the peripheral bus
  localparam logic [1:0] REG_PENDING  = 2'd0;
  localparam logic [1:0] REG_ENABLE   = 2'd1;
  localparam logic [1:0] REG_CLAIM    = 2'd2;
  localparam logic [1:0] REG_COMPLETE = 2'd3;

  // Bit of the CLAIM read word that flags a successful claim
  localparam int CLAIM_VALID_BIT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NOTIFY = 2'd1,
    IN_SVC = 2'd2
  } irq_state_t;

  // Build the CLAIM read word for a successful claim of source 'id'
  function automatic logic [BUS_W-1:0] claim_word(input logic [BUS_W-2:0] id);
    logic [BUS_W-1:0] word;
    word                  = {1'b0, id};
    word[CLAIM_VALID_BIT] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus seen by the interrupt controller: active-low address
// strobe and write enable, chip select, register offset and data paths.
interface irq_controller_if;
  import irq_controller_pkg::*;

  logic             AS_L;
  logic             WE_L;
  logic             cs;
  logic [1:0]       reg_addr;
  logic [BUS_W-1:0] data_in;
  logic [BUS_W-1:0] data_out;

  modport master (
    output AS_L, WE_L, cs, reg_addr, data_in,
    input  data_out
  );

  modport slave (
    input  AS_L, WE_L, cs, reg_addr, data_in,
    output data_out
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the lowest set request bit (lowest index has highest priority).
module irq_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the previous value.
    any = |req;
    id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches peripheral requests as pending, masks them
// with ENABLE, and raises cpu_irq for the highest-priority (lowest index)
// enabled source. The CPU claims via a CLAIM read and retires the service
// with a COMPLETE write of the claimed ID. No nesting.
//
// Build option: define IRQ_CONTROLLER_EDGE_EN to latch pending on rising
// edges of irq_src instead of on level.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq
);

  localparam logic [NUM_SRC-1:0] ONE_SRC = NUM_SRC'(1);

  logic               as_l_prev;
  logic               acc;
  logic               rd_acc;
  logic               wr_acc;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] pend_set;
  logic [NUM_SRC-1:0] pend_clr;
  logic [ID_W-1:0]    in_service_id;
  logic [ID_W-1:0]    top_id;
  logic               top_any;
  logic               claim_valid;
  logic               claim_fire;
  logic               complete_fire;
  logic [BUS_W-1:0]   rd_data;
  irq_state_t         state;
  irq_state_t         state_next;

  // Only the low bits of the write data carry meaning for this block
  logic unused_data_in;
  assign unused_data_in = &{1'b0, bus.data_in};

  // One access per bus cycle: fire only on the falling edge of AS_L
  assign acc    = bus.cs & ~bus.AS_L & as_l_prev;
  assign rd_acc = acc &  bus.WE_L;
  assign wr_acc = acc & ~bus.WE_L;

  assign active = pending & enable;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req (active),
    .any (top_any),
    .id  (top_id)
  );

  assign claim_valid   = (state == NOTIFY) && top_any;
  assign claim_fire    = rd_acc && (bus.reg_addr == REG_CLAIM) && claim_valid;
  assign complete_fire = wr_acc && (bus.reg_addr == REG_COMPLETE) &&
                         (state == IN_SVC) &&
                         (bus.data_in[ID_W-1:0] == in_service_id);

  // A claim retires the claimed source's pending bit
  assign pend_clr = claim_fire ? (ONE_SRC << top_id) : '0;

  // Previous AS_L level for access-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is always written with non-blocking '<=' so all
    // flops update together from pre-edge values, independent of block order.
    if (!reset_n) as_l_prev <= 1'b1;
    else          as_l_prev <= bus.AS_L;
  end

`ifdef IRQ_CONTROLLER_EDGE_EN
  logic [NUM_SRC-1:0] irq_prev;

  // Previous source levels for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_prev <= '0;
    else          irq_prev <= irq_src;
  end

  assign pend_set = irq_src & ~irq_prev;
`else
  logic [NUM_SRC-1:0] svc_mask;

  // Hide the source being claimed or serviced so its held level cannot re-pend
  always_comb begin
    svc_mask = '0;
    if (claim_fire)            svc_mask = ONE_SRC << top_id;
    else if (state == IN_SVC)  svc_mask = ONE_SRC << in_service_id;
  end

  assign pend_set = irq_src & ~svc_mask;
`endif

  // Pending latch (set wins over clear), enable register and in-service ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      enable        <= '0;
      in_service_id <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;
      if (wr_acc && (bus.reg_addr == REG_ENABLE)) enable <= bus.data_in[NUM_SRC-1:0];
      if (claim_fire) in_service_id <= top_id;
    end
  end

  // Controller state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: notify, claim, complete
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (top_any) state_next = NOTIFY;
      NOTIFY: begin
        if (claim_fire)    state_next = IN_SVC;
        else if (!top_any) state_next = IDLE;
      end
      IN_SVC:  if (complete_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered interrupt line tracks the NOTIFY state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_irq <= 1'b0;
    else          cpu_irq <= (state_next == NOTIFY);
  end

  // Read-data selection for the addressed register
  always_comb begin
    rd_data = '0;
    unique case (bus.reg_addr)
      REG_PENDING: rd_data[NUM_SRC-1:0] = pending;
      REG_ENABLE:  rd_data[NUM_SRC-1:0] = enable;
      REG_CLAIM:   if (claim_valid) rd_data = claim_word((BUS_W-1)'(top_id));
      default:     rd_data = '0;
    endcase
  end

  // Read data is captured once per read access and held until the next read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    bus.data_out <= '0;
    else if (rd_acc) bus.data_out <= rd_data;
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller. Covers both the default
// level build and the IRQ_CONTROLLER_EDGE_EN build.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 5;

  logic               clk     = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic               cpu_irq;
  logic [31:0]        rd;
  int                 n_checks = 0;
  int                 n_fails  = 0;

  irq_controller_if bus_if ();

  irq_controller #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq_src (irq_src),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus cycle starting at a negedge; AS_L low for 'hold' edges, then
  // one idle edge so the next access sees a fresh falling strobe.
  task automatic bus_cycle(input logic we_l, input logic [1:0] addr,
                           input logic [31:0] wdata, input int hold);
    bus_if.cs       = 1'b1;
    bus_if.AS_L     = 1'b0;
    bus_if.WE_L     = we_l;
    bus_if.reg_addr = addr;
    bus_if.data_in  = wdata;
    tick(hold);
    bus_if.cs       = 1'b0;
    bus_if.AS_L     = 1'b1;
    bus_if.WE_L     = 1'b1;
    tick(1);
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [31:0] wdata);
    bus_cycle(1'b0, addr, wdata, 1);
  endtask

  task automatic bus_rd(input logic [1:0] addr, output logic [31:0] data);
    bus_cycle(1'b1, addr, 32'h0, 1);
    data = bus_if.data_out;
  endtask

  initial begin
    bus_if.AS_L     = 1'b1;
    bus_if.WE_L     = 1'b1;
    bus_if.cs       = 1'b0;
    bus_if.reg_addr = 2'd0;
    bus_if.data_in  = 32'h0;

    // Reset state
    tick(2);
    check("rst_cpu_irq",  32'(cpu_irq),        32'h0);
    check("rst_data_out", bus_if.data_out,     32'h0);
    check("rst_pending",  32'(dut.pending),    32'h0);
    reset_n = 1'b1;
    tick(1);

    // Single source, claim and complete
    bus_wr(REG_ENABLE, 32'h04);
    irq_src = 8'h04;
    tick(1);
    check("t1_irq_latch_cycle", 32'(cpu_irq), 32'h0);
    irq_src = 8'h00;
    tick(1);
    check("t1_irq_rise", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t1_claim",    rd,           32'h8000_0002);
    check("t1_irq_fall", 32'(cpu_irq), 32'h0);
    bus_wr(REG_COMPLETE, 32'h2);
    check("t1_state_idle", 32'(dut.state), 32'(IDLE));
    irq_src = 8'h04;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    check("t1_irq_again", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t1_claim_again", rd, 32'h8000_0002);
    bus_wr(REG_COMPLETE, 32'h2);

    // Two simultaneous sources: lower index first
    bus_wr(REG_ENABLE, 32'hFF);
    irq_src = 8'h28;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    check("t2_irq_rise", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t2_claim_3", rd, 32'h8000_0003);
    bus_wr(REG_COMPLETE, 32'h3);
    check("t2_irq_reassert", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t2_claim_5", rd, 32'h8000_0005);
    bus_wr(REG_COMPLETE, 32'h5);
    check("t2_irq_quiet", 32'(cpu_irq), 32'h0);

    // Claim with nothing pending, claim during service, wrong complete ID
    bus_rd(REG_CLAIM, rd);
    check("t3_claim_empty", rd,             32'h0);
    check("t3_state_idle",  32'(dut.state), 32'(IDLE));
    irq_src = 8'h02;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    check("t3_irq_rise", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t3_claim_1", rd, 32'h8000_0001);
    irq_src = 8'h01;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    bus_rd(REG_CLAIM, rd);
    check("t3_claim_in_svc", rd,           32'h0);
    check("t3_no_nest_irq",  32'(cpu_irq), 32'h0);
    bus_wr(REG_COMPLETE, 32'h4);
    check("t3_wrong_id_irq",   32'(cpu_irq),   32'h0);
    check("t3_wrong_id_state", 32'(dut.state), 32'(IN_SVC));
    bus_rd(REG_PENDING, rd);
    check("t3_pending_src0", rd, 32'h01);
    bus_wr(REG_COMPLETE, 32'h1);
    check("t3_irq_src0", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t3_claim_0", rd, 32'h8000_0000);
    bus_wr(REG_COMPLETE, 32'h0);

    // Long AS_L on CLAIM: exactly one side effect
    irq_src = 8'h14;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    check("t4_irq_rise", 32'(cpu_irq), 32'h1);
    bus_cycle(1'b1, REG_CLAIM, 32'h0, 5);
    check("t4_claim_long", bus_if.data_out, 32'h8000_0002);
    check("t4_irq_fall",   32'(cpu_irq),    32'h0);
    check("t4_state",      32'(dut.state),  32'(IN_SVC));
    bus_rd(REG_PENDING, rd);
    check("t4_pending_one_cleared", rd, 32'h10);
    bus_wr(REG_COMPLETE, 32'h2);
    bus_rd(REG_CLAIM, rd);
    check("t4_claim_4", rd, 32'h8000_0004);
    bus_wr(REG_COMPLETE, 32'h4);

    // Disabled source still pends; enabling it raises the line
    bus_wr(REG_ENABLE, 32'h00);
    irq_src = 8'h01;
    tick(3);
    bus_rd(REG_PENDING, rd);
    check("t5_pending_disabled", rd,           32'h01);
    check("t5_irq_masked",       32'(cpu_irq), 32'h0);
    bus_wr(REG_ENABLE, 32'h01);
    check("t5_irq_enabled", 32'(cpu_irq), 32'h1);
    bus_rd(REG_CLAIM, rd);
    check("t5_claim_0", rd, 32'h8000_0000);
    bus_rd(REG_PENDING, rd);
    check("t5_pending_in_svc", rd, 32'h00);
    bus_wr(REG_COMPLETE, 32'h0);
    tick(1);

`ifdef IRQ_CONTROLLER_EDGE_EN
    // Held source does not re-pend; a new edge does
    check("t6_edge_no_repend", 32'(cpu_irq), 32'h0);
    tick(2);
    check("t6_edge_still_quiet", 32'(cpu_irq), 32'h0);
    irq_src = 8'h00;
    tick(1);
    irq_src = 8'h01;
    tick(2);
    check("t6_edge_new_edge", 32'(cpu_irq), 32'h1);
`else
    // Held source re-pends once service ends
    check("t6_level_repend", 32'(cpu_irq), 32'h1);
`endif
    bus_rd(REG_CLAIM, rd);
    check("t6_claim_0", rd,           32'h8000_0000);
    check("t6_in_svc",  32'(cpu_irq), 32'h0);

    // Reset during service, source still held high
    reset_n = 1'b0;
    #1;
    check("t7_rst_cpu_irq",  32'(cpu_irq),     32'h0);
    check("t7_rst_data_out", bus_if.data_out,  32'h0);
    check("t7_rst_pending",  32'(dut.pending), 32'h0);
    check("t7_rst_state",    32'(dut.state),   32'(IDLE));
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("t7_repend_after_rst", 32'(dut.pending), 32'h01);
    bus_wr(REG_PENDING, 32'h0);
    bus_rd(REG_PENDING, rd);
    check("t7_pending_wr_ignored", rd,           32'h01);
    check("t7_irq_enable_cleared", 32'(cpu_irq), 32'h0);
    irq_src = 8'h00;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
